// File: rtl/byte_strobe_tx_pkg.sv
// Shared types and frame constants for the byte strobe transmitter and its pixel receiver.
// No logic; pure typedefs and localparams.
package byte_strobe_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } tx_state_t;

  localparam int FRAME_ROWS          = 480;
  localparam int FRAME_COLS          = 637;
  localparam int BYTES_PER_PIXEL     = 3;
  localparam int FRAME_BYTES_DEFAULT = FRAME_ROWS * FRAME_COLS * BYTES_PER_PIXEL;

  // 20 bits covers the default frame size (917280 < 2**20).
  localparam int BYTE_CNT_W = 20;

endpackage

// File: rtl/byte_strobe_tx_if.sv
// Byte queue input and strobed pixel-bus output of the transmitter.
// master = byte producer / observer, slave = transmitter.
interface byte_strobe_tx_if;
  import byte_strobe_tx_pkg::*;

  logic [7:0]            WR_DATA;
  logic                  WR_EN;
  logic                  FULL;
  logic                  OVF;
  logic [7:0]            DATA;
  logic                  DATAIN;
  logic                  BUSY;
  logic [BYTE_CNT_W-1:0] BYTE_CNT;
  logic                  FRAME_DONE;

  modport master (
    output WR_DATA, WR_EN,
    input  FULL, OVF, DATA, DATAIN, BUSY, BYTE_CNT, FRAME_DONE
  );

  modport slave (
    input  WR_DATA, WR_EN,
    output FULL, OVF, DATA, DATAIN, BUSY, BYTE_CNT, FRAME_DONE
  );

endinterface

// File: rtl/byte_fifo.sv
// Synchronous FIFO, DEPTH a power of two; head visible on dout with no read latency.
// Backpressure: full/empty are registered; push while full and pop while empty are ignored.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_CNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/byte_strobe_tx.sv
// Queues bytes and presents each on DATA with a HOLD-high / HOLD-low DATAIN strobe; push-to-strobe latency 2 cycles.
// Backpressure: FULL is advisory; pushes while FULL are dropped and latch OVF until reset.
module byte_strobe_tx
  import byte_strobe_tx_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD        = 3,
  parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT
) (
  input logic              CLK,
  input logic              RSTN,
  byte_strobe_tx_if.slave  bus
);

  localparam int CNT_W = $clog2(HOLD) + 1;
  localparam logic [CNT_W-1:0]      HOLD_LAST  = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0]      HOLD_ONE   = CNT_W'(1);
  localparam logic [BYTE_CNT_W-1:0] FRAME_LAST = BYTE_CNT_W'(FRAME_BYTES - 1);
  localparam logic [BYTE_CNT_W-1:0] BYTE_ONE   = BYTE_CNT_W'(1);

  tx_state_t             state_q;
  tx_state_t             state_nxt;
  logic [CNT_W-1:0]      hold_cnt;
  logic                  phase_done;
  logic                  byte_done;
  logic                  datain;
  logic                  fifo_pop;
  logic [7:0]            fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [7:0]            data_q;
  logic                  ovf_q;
  logic [BYTE_CNT_W-1:0] byte_cnt_q;
  logic                  frame_done_q;

  byte_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (CLK),
    .rstn  (RSTN),
    .push  (bus.WR_EN),
    .pop   (fifo_pop),
    .din   (bus.WR_DATA),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign phase_done = (hold_cnt == '0);
  assign byte_done  = (state_q == LOW) && phase_done;

  always_ff @(posedge CLK) begin
    if (!RSTN) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: if (!fifo_empty) state_nxt = LOAD;
      LOAD: state_nxt = HIGH;
      HIGH: if (phase_done) state_nxt = LOW;
      LOW:  if (phase_done) state_nxt = fifo_empty ? IDLE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // The head is popped on the edge that enters LOAD, so DATA is valid throughout LOAD.
  always_comb begin
    datain   = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE:    fifo_pop = !fifo_empty;
      HIGH:    datain   = 1'b1;
      LOW:     fifo_pop = phase_done && !fifo_empty;
      default: begin
        datain   = 1'b0;
        fifo_pop = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      hold_cnt     <= '0;
      data_q       <= 8'h00;
      ovf_q        <= 1'b0;
      byte_cnt_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      if (state_nxt != state_q) hold_cnt <= HOLD_LAST;
      else if (!phase_done)     hold_cnt <= hold_cnt - HOLD_ONE;

      if (fifo_pop) data_q <= fifo_dout;

      // FULL is the registered pre-pop value, so a push racing a pop while full is still dropped.
      if (bus.WR_EN && fifo_full) ovf_q <= 1'b1;

      frame_done_q <= 1'b0;
      if (byte_done) begin
        if (byte_cnt_q == FRAME_LAST) begin
          byte_cnt_q   <= '0;
          frame_done_q <= 1'b1;
        end else begin
          byte_cnt_q <= byte_cnt_q + BYTE_ONE;
        end
      end
    end
  end

  assign bus.FULL       = fifo_full;
  assign bus.OVF        = ovf_q;
  assign bus.DATA       = data_q;
  assign bus.DATAIN     = datain;
  assign bus.BUSY       = (state_q != IDLE) || !fifo_empty;
  assign bus.BYTE_CNT   = byte_cnt_q;
  assign bus.FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_byte_strobe_tx.sv
// Directed bench for byte_strobe_tx with a 5-byte frame; a behavioural pixel receiver
// captures DATA on each DATAIN rising edge.
module tb_byte_strobe_tx;
  import byte_strobe_tx_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  byte_strobe_tx_if bus ();

  byte_strobe_tx #(
    .DEPTH       (4),
    .HOLD        (3),
    .FRAME_BYTES (5)
  ) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  // Pixel receiver: byte k of a window lands in rx_q[k] (IN0..IN8).
  logic [7:0] rx_q [$];
  int         rx_cyc [$];
  int         cyc = 0;
  logic       strobe_prev = 1'b0;

  always @(posedge clk) begin
    if (bus.DATAIN === 1'b1 && strobe_prev === 1'b0) begin
      rx_q.push_back(bus.DATA);
      rx_cyc.push_back(cyc);
    end
    strobe_prev = bus.DATAIN;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn        = 1'b0;
    bus.WR_EN   = 1'b0;
    bus.WR_DATA = 8'h00;
    tick();
    tick();
    rstn = 1'b1;
    rx_q.delete();
    rx_cyc.delete();
  endtask

  task automatic push_seq(input logic [7:0] first, input int n);
    logic [7:0] b;
    b = first;
    for (int i = 0; i < n; i++) begin
      bus.WR_DATA = b;
      bus.WR_EN   = 1'b1;
      tick();
      b = b + 8'h01;
    end
    bus.WR_EN = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin
      tick();
      t++;
    end
    n_checks++;
    if (rx_q.size() < n) begin
      n_fail++;
      $display("FAIL %s_rx_timeout: got %0d strobes, want %0d", name, rx_q.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int t;
    t = 0;
    while (bus.BUSY !== 1'b0 && t < budget) begin
      tick();
      t++;
    end
    n_checks++;
    if (bus.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: BUSY=%b want 0", name, bus.BUSY);
    end
  endtask

  task automatic test_reset();
    logic [31:0] got;
    apply_reset();
    got = {bus.FULL, bus.OVF, bus.DATA, bus.DATAIN, bus.BUSY, bus.BYTE_CNT[19:0]};
    n_checks++;
    if (got !== 32'h0 || bus.FRAME_DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %h frame_done=%b want 0", got, bus.FRAME_DONE);
    end
  endtask

  task automatic test_single_byte();
    logic       exp_strobe;
    logic [19:0] exp_cnt;
    apply_reset();
    push_seq(8'hA5, 1);
    n_checks++;
    if (bus.BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_c0: got %b want 1", bus.BUSY);
    end
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp_strobe = (c >= 2 && c <= 4);
      exp_cnt    = (c == 8) ? 20'd1 : 20'd0;
      n_checks++;
      if (bus.DATAIN !== exp_strobe) begin
        n_fail++;
        $display("FAIL single_datain_c%0d: got %b want %b", c, bus.DATAIN, exp_strobe);
      end
      n_checks++;
      if (bus.DATA !== 8'hA5) begin
        n_fail++;
        $display("FAIL single_data_c%0d: got %h want a5", c, bus.DATA);
      end
      n_checks++;
      if (bus.BYTE_CNT !== exp_cnt) begin
        n_fail++;
        $display("FAIL single_cnt_c%0d: got %0d want %0d", c, bus.BYTE_CNT, exp_cnt);
      end
    end
    n_checks++;
    if (bus.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_c8: got %b want 0", bus.BUSY);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    push_seq(8'h01, 4);
    wait_rx(4, 60, "stream");
    wait_idle(40, "stream");
    n_checks++;
    if (rx_q.size() != 4) begin
      n_fail++;
      $display("FAIL stream_count: got %0d want 4", rx_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < 4; i++) begin
      n_checks++;
      if (rx_q[i] !== 8'(i + 1)) begin
        n_fail++;
        $display("FAIL stream_byte%0d: got %h want %h", i, rx_q[i], 8'(i + 1));
      end
      if (i > 0) begin
        n_checks++;
        if (rx_cyc[i] - rx_cyc[i-1] != 7) begin
          n_fail++;
          $display("FAIL stream_period%0d: got %0d want 7", i, rx_cyc[i] - rx_cyc[i-1]);
        end
      end
    end
    n_checks++;
    if (bus.OVF !== 1'b0 || bus.BYTE_CNT !== 20'd4) begin
      n_fail++;
      $display("FAIL stream_ovf_cnt: ovf=%b cnt=%0d want 0 4", bus.OVF, bus.BYTE_CNT);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      bus.WR_DATA = 8'h10 + 8'(i);
      bus.WR_EN   = 1'b1;
      tick();
      if (i == 4) begin
        n_checks++;
        if (bus.FULL !== 1'b1 || bus.OVF !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_full_after5: full=%b ovf=%b want 1 0", bus.FULL, bus.OVF);
        end
      end
    end
    bus.WR_EN = 1'b0;
    n_checks++;
    if (bus.OVF !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %b want 1", bus.OVF);
    end
    wait_idle(80, "ovf");
    n_checks++;
    if (rx_q.size() != 5) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d want 5", rx_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < 5; i++) begin
      n_checks++;
      if (rx_q[i] !== 8'h10 + 8'(i)) begin
        n_fail++;
        $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], 8'h10 + 8'(i));
      end
    end
    n_checks++;
    if (bus.OVF !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b want 1", bus.OVF);
    end
  endtask

  task automatic test_frame_wrap();
    int          pulses;
    logic [19:0] prev_cnt;
    apply_reset();
    push_seq(8'h50, 5);
    pulses   = 0;
    prev_cnt = bus.BYTE_CNT;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (bus.FRAME_DONE === 1'b1) begin
        pulses++;
        n_checks++;
        if (bus.BYTE_CNT !== 20'd0 || prev_cnt !== 20'd4) begin
          n_fail++;
          $display("FAIL frame_wrap_cnt: cnt %0d->%0d want 4->0", prev_cnt, bus.BYTE_CNT);
        end
      end
      prev_cnt = bus.BYTE_CNT;
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL frame_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_mid_byte_reset();
    apply_reset();
    push_seq(8'hA1, 3);
    n_checks++;
    if (bus.DATAIN !== 1'b1 || bus.DATA !== 8'hA1) begin
      n_fail++;
      $display("FAIL midrst_in_high: datain=%b data=%h want 1 a1", bus.DATAIN, bus.DATA);
    end
    rstn = 1'b0;
    tick();
    n_checks++;
    if (bus.DATAIN !== 1'b0 || bus.DATA !== 8'h00 || bus.BUSY !== 1'b0 || bus.FULL !== 1'b0
        || bus.BYTE_CNT !== 20'd0) begin
      n_fail++;
      $display("FAIL midrst_state: datain=%b data=%h busy=%b full=%b cnt=%0d want 0 00 0 0 0",
               bus.DATAIN, bus.DATA, bus.BUSY, bus.FULL, bus.BYTE_CNT);
    end
    rstn = 1'b1;
    rx_q.delete();
    rx_cyc.delete();
    repeat (30) tick();
    n_checks++;
    if (rx_q.size() != 0 || bus.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_strobe: strobes=%0d busy=%b want 0 0", rx_q.size(), bus.BUSY);
    end
  endtask

  task automatic test_window_e2e();
    logic [7:0] px [9];
    int         t;
    px = '{8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23, 8'h31, 8'h32, 8'h33};
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      t = 0;
      while (bus.FULL === 1'b1 && t < 50) begin
        tick();
        t++;
      end
      bus.WR_DATA = px[k];
      bus.WR_EN   = 1'b1;
      tick();
      bus.WR_EN = 1'b0;
    end
    wait_rx(9, 200, "e2e");
    for (int k = 0; k < rx_q.size() && k < 9; k++) begin
      n_checks++;
      if (rx_q[k] !== px[k]) begin
        n_fail++;
        $display("FAIL e2e_in%0d: got %h want %h", k, rx_q[k], px[k]);
      end
    end
    wait_idle(40, "e2e");
    n_checks++;
    if (bus.OVF !== 1'b0 || bus.BYTE_CNT !== 20'd4) begin
      n_fail++;
      $display("FAIL e2e_ovf_cnt: ovf=%b cnt=%0d want 0 4", bus.OVF, bus.BYTE_CNT);
    end
  endtask

  initial begin
    bus.WR_EN   = 1'b0;
    bus.WR_DATA = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_frame_wrap();
    test_mid_byte_reset();
    test_window_e2e();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_strobe_tx.md
BYTE_STROBE_TX -- requirements
Module: byte_strobe_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO depth in bytes (power of two, >=2).
REQ-002 SHALL have parameter HOLD, default 3, clock cycles DATAIN is held high and held low per byte (>=1).
REQ-003 SHALL have parameter FRAME_BYTES, default 917280 (480*637*3), bytes per frame.
REQ-004 SHALL have port CLK  input  1  single clock; every register updates on the rising edge.
REQ-005 SHALL have port RSTN  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port WR_DATA  input  8  byte to queue.
REQ-007 SHALL have port WR_EN  input  1  push WR_DATA this cycle.
REQ-008 SHALL have port FULL  output  1  FIFO holds DEPTH bytes.
REQ-009 SHALL have port OVF  output  1  sticky flag: a push was dropped.
REQ-010 SHALL have port DATA  output  8  byte presented to the pixel receiver.
REQ-011 SHALL have port DATAIN  output  1  byte strobe; the rising edge marks DATA valid.
REQ-012 SHALL have port BUSY  output  1  a byte is being sent or the FIFO is non-empty.
REQ-013 SHALL have port BYTE_CNT  output  20  bytes sent in the current frame.
REQ-014 SHALL have port FRAME_DONE  output  1  one-cycle pulse when the last byte of a frame completes.

Function
REQ-015 SHALL implement a FIFO of DEPTH bytes with registered FULL.
- A push with WR_EN=1 and FULL=0 is accepted.
- A push with WR_EN=1 and FULL=1 is dropped and sets OVF.
REQ-016 SHALL treat WR_EN=1 while FULL=1, in the same cycle as a pop, as a drop, because FULL is evaluated before the pop.
REQ-017 SHALL use an FSM with states IDLE, LOAD, HIGH and LOW.
REQ-018 SHALL behave as follows in IDLE: DATAIN=0; if the FIFO is non-empty, pop the head and go to LOAD.
REQ-019 SHALL behave as follows in LOAD (1 cycle): DATA takes the popped byte, DATAIN stays 0, go to HIGH.
REQ-020 SHALL behave as follows in HIGH: DATAIN=1 for exactly HOLD cycles, then go to LOW.
REQ-021 SHALL behave as follows in LOW: DATAIN=0 for exactly HOLD cycles, then:
- increment BYTE_CNT;
- go directly to LOAD, popping the next byte, if the FIFO is non-empty;
- otherwise go to IDLE.
REQ-022 SHALL give a byte period of 1+2*HOLD cycles (7 at default) when streaming back-to-back.
REQ-023 SHALL hold DATA stable from LOAD until the next LOAD; DATA SHALL NOT change while DATAIN=1.
REQ-024 SHALL give a latency of 2 cycles from an accepted push into an empty, IDLE block to the DATAIN rising edge (push, LOAD, HIGH).
REQ-025 SHALL, at the end of LOW when BYTE_CNT would reach FRAME_BYTES:
- reset BYTE_CNT to 0 (wrap);
- pulse FRAME_DONE for that single cycle.
REQ-026 SHALL count the HOLD phases with a counter of width clog2(HOLD)+1 that reloads on every state entry.
REQ-027 SHALL drive BUSY = (state != IDLE) | FIFO non-empty.
REQ-028 SHALL NOT clear OVF except by reset.

Reset
REQ-029 SHALL, on RSTN=0 at a rising CLK edge, regardless of the current state (mid-byte included), set:
- state to IDLE;
- FIFO empty and FULL=0;
- OVF=0;
- DATA=8'h00, DATAIN=0;
- BUSY=0;
- BYTE_CNT=0, FRAME_DONE=0.
REQ-030 SHALL discard a byte interrupted by reset; no strobe edge is emitted for it.

Structure
REQ-031 SHALL place the state encoding (IDLE, LOAD, HIGH, LOW) and the default frame constants (480 rows, 637 columns, 3 bytes per pixel) in a shared package used by the pixel receiver and the bench.
REQ-032 SHALL implement the FIFO as a sub-module byte_fifo (synchronous, same reset) with:
- inputs: push, pop, din;
- outputs: dout, full, empty.

Verification
REQ-033 SHALL cover a single byte: push 8'hA5 into the idle block -> DATA=A5 at cycle 1, DATAIN high at cycles 2-4 and low at cycles 5-7, BYTE_CNT=1, BUSY=0 at cycle 8.
REQ-034 SHALL cover streaming: push 8'h01..8'h04 on consecutive cycles -> four rising edges of DATAIN, each 7 cycles apart, carrying 01,02,03,04 in order, OVF=0.
REQ-035 SHALL cover overflow: push 6 bytes on consecutive cycles with DEPTH=4 -> the 6th byte is dropped, OVF=1 and stays 1, exactly 5 bytes are emitted.
REQ-036 SHALL cover frame wrap: FRAME_BYTES=5, send 5 bytes -> one FRAME_DONE pulse in the cycle BYTE_CNT wraps 4->0.
REQ-037 SHALL cover mid-byte reset: assert RSTN=0 during HIGH with 2 bytes queued -> next cycle DATAIN=0, DATA=00, FIFO empty, and no further strobe without new pushes.
REQ-038 SHALL cover end-to-end: drive the pixel receiver with 9 bytes forming a 3x3 window -> the receiver's IN0..IN8 match the sent sequence.
